ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter for the keyboard port (clkps2/dataps2): sends a command byte (LED set,

---
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter for the keyboard port. Sends one
//            command byte (start, 8 data bits LSB first, odd parity, stop),
//            then checks the device ACK. Open-drain style: a line is only
//            ever pulled low through its *_oe output.
// Ports    : clk_chipset    - system clock, rising edge
//            reset          - synchronous, active-high
//            tx_data[7:0]   - command byte, latched on accept
//            tx_valid       - request, accepted when tx_valid && tx_ready
//            tx_ready       - high only while idle
//            tx_done        - 1-cycle pulse, frame sent and ACK seen
//            tx_error       - 1-cycle pulse, timeout or missing ACK
//            ps2_clk_i      - raw PS/2 clock pin (asynchronous)
//            ps2_data_i     - raw PS/2 data pin (asynchronous)
//            ps2_clk_oe     - 1 = pull PS/2 clock low
//            ps2_data_oe    - 1 = pull PS/2 data low
//            ps2_rx_inhibit - high whenever a transfer is in progress
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk_chipset,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       ps2_rx_inhibit
);

  // One shared counter times the inhibit, request and watchdog intervals.
  localparam int c_MAX_IR  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int c_CNT_MAX = (TIMEOUT_CYCLES > c_MAX_IR) ? TIMEOUT_CYCLES : c_MAX_IR;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);
  localparam int c_FW      = $clog2(FILTER_CYCLES + 1);

  localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
  localparam logic [c_CW-1:0] c_REQ_LAST = c_CW'(REQ_CYCLES - 1);
  localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_FW-1:0] c_FLT_LAST = c_FW'(FILTER_CYCLES - 1);

  if (CLK_HZ <= 0 || FILTER_CYCLES < 1 || INHIBIT_CYCLES < 1 ||
      REQ_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: all timing parameters must be positive");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic [9:0]        shreg_q, shreg_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;

  logic [1:0]        clk_sync_q;
  logic [1:0]        data_sync_q;
  logic              clk_filt_q;
  logic [c_FW-1:0]   filt_cnt_q;

  logic              w_clk_s;
  logic              w_data_s;
  logic              w_fall;

  assign w_clk_s  = clk_sync_q[1];
  assign w_data_s = data_sync_q[1];

  // A level change is accepted only after FILTER_CYCLES consecutive samples
  // that disagree with the current filtered level; the fall strobe fires on
  // the cycle that the filtered level drops.
  assign w_fall = clk_filt_q && !w_clk_s && (filt_cnt_q == c_FLT_LAST);

  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (w_clk_s != clk_filt_q) begin
        if (filt_cnt_q == c_FLT_LAST) begin
          clk_filt_q <= w_clk_s;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + c_FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Line enables are computed together with the next state so they come
  // straight from flops and change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d  = ST_INHIBIT;
          cnt_d    = '0;
          shreg_d  = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          clk_oe_d = 1'b1;
        end
      end

      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == c_INH_LAST) begin
          state_d   = ST_REQ;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end

      ST_REQ: begin
        data_oe_d = 1'b1;
        if (cnt_q == c_REQ_LAST) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end else begin
          clk_oe_d = 1'b1;
          cnt_d    = cnt_q + c_CW'(1);
        end
      end

      ST_SEND: begin
        // Start bit is already on the line; each device fall moves the next
        // frame bit out, the tenth one leaves the stop bit (line released).
        data_oe_d = data_oe_q;
        if (w_fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[9:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          cnt_d     = '0;
          if (bitcnt_q == 4'd9) begin
            state_d = ST_ACK;
          end
        end else if (cnt_q == c_TO_LAST) begin
          state_d   = ST_ERR;
          data_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end

      ST_ACK: begin
        if (w_fall) begin
          cnt_d   = '0;
          state_d = w_data_s ? ST_ERR : ST_WAIT_IDLE;
        end else if (cnt_q == c_TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_filt_q && w_data_s) begin
          state_d = ST_DONE;
        end else if (cnt_q == c_TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_ready       = (state_q == ST_IDLE);
  assign tx_done        = (state_q == ST_DONE);
  assign tx_error       = (state_q == ST_ERR);
  assign ps2_rx_inhibit = (state_q != ST_IDLE);
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Bench for ps2_host_tx. A PS/2 device model clocks frames out of
//            the host and records the bits it sees; a per-cycle model of the
//            host's request timing and result pulses is checked against the
//            DUT outputs. Timing parameters are scaled down to keep runs short.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RQ   = 16;
  localparam int TO   = 2000;
  localparam int FILT = 8;
  localparam int H    = 40;   // device clock half period in system cycles

  logic       clk_chipset = 1'b0;
  logic       reset       = 1'b1;
  logic [7:0] tx_data     = 8'h00;
  logic       tx_valid    = 1'b0;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe, ps2_rx_inhibit;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       bus_clk, bus_data;

  assign bus_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign bus_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ        (50_000_000),
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TO),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk_chipset   (clk_chipset),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_done       (tx_done),
    .tx_error      (tx_error),
    .ps2_clk_i     (bus_clk),
    .ps2_data_i    (bus_data),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .ps2_rx_inhibit(ps2_rx_inhibit)
  );

  always #5 clk_chipset = ~clk_chipset;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  int n_errp = 0;
  // 0: no pulse allowed, 1: done, 2: missing ACK, 3: watchdog
  int exp_outcome = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  // ---------------------------------------------------------------------
  // Per-cycle model: cycles since accept decide the expected line enables
  // through the inhibit and request phases; result pulses must match the
  // outcome the running test expects.
  // ---------------------------------------------------------------------
  logic m_busy   = 1'b0;
  logic m_end    = 1'b0;
  logic rst_prev = 1'b0;
  logic acc_prev = 1'b0;
  int   m_cyc    = 0;

  always @(negedge clk_chipset) begin
    if (rst_prev || m_end) begin
      m_busy = 1'b0;
    end else if (acc_prev) begin
      m_busy = 1'b1;
      m_cyc  = 0;
    end else if (m_busy) begin
      m_cyc++;
    end
    m_end = 1'b0;

    chk("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
    if (m_busy) begin
      chk("busy_ready", 32'(tx_ready), 32'd0);
      chk("busy_inhibit", 32'(ps2_rx_inhibit), 32'd1);
      if (m_cyc < INH) begin
        chk("inhibit_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b10);
      end else if (m_cyc < INH + RQ) begin
        chk("req_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
      end else begin
        chk("send_clk_oe", 32'(ps2_clk_oe), 32'd0);
        if (m_cyc == INH + RQ)
          chk("start_bit_oe", 32'(ps2_data_oe), 32'd1);
      end
      if (tx_done || tx_error) begin
        chk("pulse_kind", 32'({tx_done, tx_error}),
            (exp_outcome == 1) ? 32'b10 : ((exp_outcome == 0) ? 32'b00 : 32'b01));
        chk("pulse_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        if (tx_error && exp_outcome == 3)
          chk("timeout_latency", 32'(m_cyc), 32'(INH + RQ + TO));
        if (tx_done)  n_done++;
        if (tx_error) n_errp++;
        m_end = 1'b1;
      end
    end else begin
      chk("idle_outputs",
          32'({tx_ready, ps2_rx_inhibit, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}),
          32'b100000);
    end

    rst_prev = reset;
    acc_prev = tx_valid && tx_ready && !reset;
  end

  // ---------------------------------------------------------------------
  // Device model: waits for the request-to-send, clocks ten bits, reading
  // the line on each rising edge, then gives (or withholds) the ACK.
  // ---------------------------------------------------------------------
  task automatic dev_frame(input bit ack_low, input bit glitch, input bit abort,
                           output logic [9:0] bits, output logic start);
    int k;
    bits  = '0;
    start = 1'b1;
    for (k = 0; k < 1000 && !(bus_clk === 1'b1 && bus_data === 1'b0); k++)
      @(negedge clk_chipset);
    chk("dev_rts_seen", 32'({bus_clk, bus_data}), 32'b10);
    repeat (20) @(negedge clk_chipset);
    start = bus_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk_chipset);
      if (abort && i == 4) begin
        @(posedge clk_chipset); #2 reset = 1'b1;
        @(posedge clk_chipset); #1;
        chk("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        chk("rst_mid_ready", 32'({tx_ready, ps2_rx_inhibit}), 32'b10);
        chk("rst_mid_pulses", 32'({tx_done, tx_error}), 32'b00);
        #1 reset = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      bits[i-1] = bus_data;
      if (glitch && i == 5) begin
        repeat (10) @(negedge clk_chipset);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk_chipset);
        dev_clk_low = 1'b0;
        repeat (H - 13) @(negedge clk_chipset);
      end else begin
        repeat (H) @(negedge clk_chipset);
      end
    end
    if (ack_low) dev_data_low = 1'b1;
    repeat (H / 2) @(negedge clk_chipset);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk_chipset);
    dev_clk_low = 1'b0;
    repeat (H / 2) @(negedge clk_chipset);
    dev_data_low = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] d);
    @(posedge clk_chipset); #2 tx_data = d; tx_valid = 1'b1;
    @(posedge clk_chipset); #2 tx_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int total, input string name);
    for (int k = 0; k < 5000 && (n_done + n_errp) < total; k++)
      @(negedge clk_chipset);
    chk(name, 32'(n_done + n_errp), 32'(total));
    repeat (2) @(negedge clk_chipset);
  endtask

  logic [9:0] cap;
  logic       cap_start;

  initial begin
    repeat (4) @(posedge clk_chipset);
    #2 reset = 1'b0;
    @(negedge clk_chipset);
    chk("reset_state", 32'({tx_ready, ps2_rx_inhibit, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}),
        32'b100000);

    // 1: 0xED with ACK
    exp_outcome = 1;
    send_req(8'hED);
    dev_frame(1'b1, 1'b0, 1'b0, cap, cap_start);
    chk("t1_start", 32'(cap_start), 32'd0);
    chk("t1_bits", 32'(cap), 32'h3ED);
    wait_pulses(1, "t1_wait");
    chk("t1_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0100);

    // 2: 0xED, device withholds ACK
    exp_outcome = 2;
    send_req(8'hED);
    dev_frame(1'b0, 1'b0, 1'b0, cap, cap_start);
    chk("t2_bits", 32'(cap), 32'(frame_of(8'hED)));
    wait_pulses(2, "t2_wait");
    chk("t2_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0101);
    chk("t2_idle", 32'({tx_ready, ps2_clk_oe, ps2_data_oe}), 32'b100);

    // 3: device never clocks
    exp_outcome = 3;
    send_req(8'hF4);
    wait_pulses(3, "t3_wait");
    chk("t3_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0102);
    chk("t3_released", 32'({bus_clk, bus_data}), 32'b11);

    // 4: reset after the fourth fall
    exp_outcome = 0;
    send_req(8'hFF);
    dev_frame(1'b1, 1'b0, 1'b1, cap, cap_start);
    repeat (100) @(negedge clk_chipset);
    chk("t4_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0102);
    chk("t4_idle", 32'({tx_ready, ps2_rx_inhibit}), 32'b10);

    // 5: 0x00 held on tx_valid while 0xED is in flight
    exp_outcome = 1;
    @(posedge clk_chipset); #2 tx_data = 8'hED; tx_valid = 1'b1;
    @(posedge clk_chipset); #2 tx_data = 8'h00;
    dev_frame(1'b1, 1'b0, 1'b0, cap, cap_start);
    chk("t5a_bits", 32'(cap), 32'h3ED);
    wait_pulses(4, "t5a_wait");
    for (int k = 0; k < 50 && !ps2_rx_inhibit; k++) @(negedge clk_chipset);
    chk("t5_reaccept", 32'(ps2_rx_inhibit), 32'd1);
    @(posedge clk_chipset); #2 tx_valid = 1'b0;
    dev_frame(1'b1, 1'b0, 1'b0, cap, cap_start);
    chk("t5b_start", 32'(cap_start), 32'd0);
    chk("t5b_bits", 32'(cap), 32'h300);
    wait_pulses(5, "t5b_wait");
    chk("t5_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0302);

    // 6: short clock glitch during the data bits
    exp_outcome = 1;
    send_req(8'hA5);
    dev_frame(1'b1, 1'b1, 1'b0, cap, cap_start);
    chk("t6_bits", 32'(cap), 32'(frame_of(8'hA5)));
    chk("t6_bits_lit", 32'(cap), 32'h3A5);
    wait_pulses(6, "t6_wait");
    chk("t6_counts", 32'({n_done[7:0], n_errp[7:0]}), 32'h0402);

    repeat (10) @(negedge clk_chipset);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(900_000);
    $display("FAIL global_timeout: simulation did not complete, n_err=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
